// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEFAULT = 15;
  localparam int unsigned DW_DEFAULT = 16;

  // One bit is enough to name either of the two requesters.
  localparam int unsigned IDX_W = 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  idx_t i_last,
  output idx_t o_winner,
  output logic o_valid
);

  // Pick the winner; o_winner is only meaningful when o_valid is high.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = idx_t'(0);
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = idx_t'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single async-read / sync-write memory.
// Each access runs IDLE -> ACC -> DONE, so one access completes every 3 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo
);

  state_t        r_state;
  state_t        w_state_next;
  logic          w_latch;

  idx_t          r_idx;
  idx_t          r_last;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  idx_t          w_winner;
  logic          w_valid;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Steer the winning requester's command toward the capture registers.
  always_comb begin
    w_sel_we    = we0;
    w_sel_addr  = addr0;
    w_sel_wdata = wdata0;
    if (w_winner == idx_t'(1)) begin
      w_sel_we    = we1;
      w_sel_addr  = addr1;
      w_sel_wdata = wdata1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    busy         = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_next = ACC;
          w_latch      = 1'b1;
        end
      end
      ACC: begin
        w_state_next = DONE;
        busy         = 1'b1;
        mem_we       = r_we;
        gnt0         = (r_idx == idx_t'(0));
        gnt1         = (r_idx == idx_t'(1));
      end
      DONE: begin
        w_state_next = IDLE;
        busy         = 1'b1;
        gnt0         = (r_idx == idx_t'(0));
        gnt1         = (r_idx == idx_t'(1));
        done0        = (r_idx == idx_t'(0));
        done1        = (r_idx == idx_t'(1));
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Command capture, read-data load and last-grant tracking.
  // r_last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= idx_t'(0);
      r_last  <= idx_t'(1);
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_latch) begin
        r_idx   <= w_winner;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ACC && !r_we) begin
        r_rdata <= mem_spo;
      end
      if (r_state == DONE) begin
        r_last <= r_idx;
      end
    end
  end

  assign mem_a = r_addr;
  assign mem_d = r_wdata;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32K x 16 memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_spo;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int            n_pass  = 0;
  int            n_total = 0;
  int            n_done;
  int            seq [8];
  logic [DW-1:0] rd;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end
  assign mem_spo = mem[mem_a];

  mem_arbiter #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .rdata   (rdata),
    .busy    (busy),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_we  (mem_we),
    .mem_spo (mem_spo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full access for one requester: raise req, wait (bounded) for its done,
  // drop req in DONE, then step back into IDLE.
  task automatic access(input int idx, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag,
                        output logic [DW-1:0] rd_o);
    bit seen;
    seen = 1'b0;
    rd_o = '0;
    if (idx == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if ((idx == 0 && done0) || (idx == 1 && done1)) begin
        seen = 1'b1;
        rd_o = rdata;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, " done seen"}, 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #12;
    check("rst gnt0",   32'(gnt0),   32'd0);
    check("rst gnt1",   32'(gnt1),   32'd0);
    check("rst done",   32'({done0, done1}), 32'd0);
    check("rst busy",   32'(busy),   32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_a",  32'(mem_a),  32'd0);
    check("rst mem_d",  32'(mem_d),  32'd0);
    check("rst rdata",  32'(rdata),  32'd0);
    rst_n = 1'b1;
    tick();

    // Write 0xBEEF to 0x0010 from requester 0, cycle by cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0010; wdata0 = 16'hBEEF;
    tick();
    check("wr acc mem_we", 32'(mem_we), 32'd1);
    check("wr acc mem_a",  32'(mem_a),  32'h0010);
    check("wr acc mem_d",  32'(mem_d),  32'hBEEF);
    check("wr acc gnt0",   32'(gnt0),   32'd1);
    check("wr acc done0",  32'(done0),  32'd0);
    tick();
    check("wr done done0",  32'(done0),  32'd1);
    check("wr done mem_we", 32'(mem_we), 32'd0);
    check("wr done mem_a",  32'(mem_a),  32'h0010);
    req0 = 1'b0;
    tick();
    check("wr idle busy",  32'(busy),  32'd0);
    check("wr idle done0", 32'(done0), 32'd0);
    check("wr mem model",  32'(mem[15'h0010]), 32'hBEEF);

    // Read it back from requester 1.
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
    tick();
    check("rd acc gnt1",   32'(gnt1),   32'd1);
    check("rd acc mem_we", 32'(mem_we), 32'd0);
    tick();
    check("rd done done1", 32'(done1), 32'd1);
    check("rd done done0", 32'(done0), 32'd0);
    check("rd rdata",      32'(rdata), 32'hBEEF);
    req1 = 1'b0;
    tick();

    // Fresh reset, then a tie: 0 first, 1 three cycles later.
    rst_n = 1'b0;
    #1;
    check("rst2 rdata", 32'(rdata), 32'd0);
    check("rst2 busy",  32'(busy),  32'd0);
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
    tick();
    check("tie acc gnt0", 32'(gnt0), 32'd1);
    check("tie acc gnt1", 32'(gnt1), 32'd0);
    tick();
    check("tie done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    tick();
    check("tie idle busy", 32'(busy), 32'd0);
    tick();
    check("tie acc2 gnt1", 32'(gnt1), 32'd1);
    tick();
    check("tie done1", 32'(done1), 32'd1);
    req1 = 1'b0;
    tick();

    // Both held 12 cycles: expect 4 completions alternating 0,1,0,1.
    n_done = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done0) begin
        if (n_done < 8) seq[n_done] = 0;
        n_done++;
      end
      if (done1) begin
        if (n_done < 8) seq[n_done] = 1;
        n_done++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr count", 32'(n_done), 32'd4);
    check("rr seq0",  32'(seq[0]), 32'd0);
    check("rr seq1",  32'(seq[1]), 32'd1);
    check("rr seq2",  32'(seq[2]), 32'd0);
    check("rr seq3",  32'(seq[3]), 32'd1);
    tick();
    check("rr idle busy", 32'(busy), 32'd0);

    // Top address write/read; address 0 untouched.
    access(0, 1'b1, 15'h0000, 16'h5A5A, "init a0", rd);
    access(0, 1'b1, 15'h7FFF, 16'h1234, "wr top", rd);
    access(1, 1'b0, 15'h7FFF, 16'h0000, "rd top", rd);
    check("rd top data", 32'(rd), 32'h1234);
    access(0, 1'b0, 15'h0000, 16'h0000, "rd a0", rd);
    check("rd a0 data", 32'(rd), 32'h5A5A);
    check("a0 mem model", 32'(mem[15'h0000]), 32'h5A5A);

    // Reset in the middle of a write's ACC cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0020; wdata0 = 16'hDEAD;
    tick();
    check("midrst pre mem_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst mem_we", 32'(mem_we), 32'd0);
    check("midrst busy",   32'(busy),   32'd0);
    check("midrst gnt0",   32'(gnt0),   32'd0);
    check("midrst mem_a",  32'(mem_a),  32'd0);
    req0 = 1'b0;
    tick();
    check("midrst no done", 32'({done0, done1}), 32'd0);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
    tick();
    check("post rst gnt0", 32'(gnt0), 32'd1);
    check("post rst gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("post rst done0", 32'(done0), 32'd1);
    check("post rst rdata", 32'(rdata), 32'hBEEF);
    tick();

    // One-cycle read pulse from requester 1 still completes.
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
    tick();
    req1 = 1'b0;
    check("pulse acc gnt1", 32'(gnt1), 32'd1);
    tick();
    check("pulse done1", 32'(done1), 32'd1);
    check("pulse rdata", 32'(rdata), 32'hBEEF);
    tick();
    check("pulse idle done1", 32'(done1), 32'd0);
    check("pulse idle busy",  32'(busy),  32'd0);
    tick();
    check("pulse stay idle", 32'(busy), 32'd0);
    check("pulse no redo",   32'(done1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 15, meaning memory address width in bits.
REQ-002 The block SHALL have parameter DW, default 16, meaning memory data width in bits.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0/1, held until its done pulse.
REQ-006 The block SHALL have ports we0/we1  input  1  write (1) or read (0) for requester 0/1.
REQ-007 The block SHALL have ports addr0/addr1  input  AW  word address for requester 0/1.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DW  write data for requester 0/1.
REQ-009 The block SHALL have ports gnt0/gnt1  output  1  requester 0/1 owns the memory (ACC and DONE states).
REQ-010 The block SHALL have ports done0/done1  output  1  one-cycle completion pulse for requester 0/1.
REQ-011 The block SHALL have port rdata  output  DW  registered read data, valid while done0 or done1 is high.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 The block SHALL have ports mem_a  output  AW, mem_d  output  DW, mem_we  output  1, mem_spo  input  DW, connecting to a 32K x 16 memory with asynchronous read and synchronous write.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, ACC and DONE; unused encodings SHALL return to IDLE.
REQ-015 In IDLE with req0 or req1 high, the FSM SHALL select a winner, latch its index, we, addr and wdata, and enter ACC on the next edge.
REQ-016 With only one request high, that requester SHALL win.
REQ-017 With both requests high, the requester not granted last SHALL win (round-robin).
REQ-018 In ACC, mem_a SHALL equal the latched address, mem_d the latched data, and mem_we the latched we; ACC SHALL last exactly one cycle.
REQ-019 In ACC, rdata SHALL be loaded from mem_spo on reads and SHALL hold its value on writes.
REQ-020 DONE SHALL last one cycle, assert done of the winner only, update the last-grant register to the winner, and then return to IDLE.
REQ-021 Request-to-done latency SHALL be 2 cycles: req seen at edge k, ACC in cycle k..k+1, done high in cycle k+1..k+2.
REQ-022 mem_we SHALL be 0 in every state except ACC, and mem_a/mem_d SHALL hold their latched values outside ACC.
REQ-023 Requests are sampled only in IDLE; a request deasserted before done SHALL not abort an access in flight.
REQ-024 A requester that holds req high through DONE SHALL be treated as a new request in the next IDLE cycle, so back-to-back throughput is one access per 3 cycles.
REQ-025 Under continuous requests from both requesters, grants SHALL alternate 0,1,0,1,...

Reset
REQ-026 Asserting rst_n low SHALL immediately force state IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, mem_we=0, mem_a=0, mem_d=0, rdata=0, and last-grant=1 so requester 0 wins the first contention.
REQ-027 Reset asserted during ACC SHALL drop mem_we asynchronously; that write is not guaranteed, and no done pulse SHALL follow.

Structure
REQ-028 State encoding, AW/DW defaults and the requester index width SHALL reside in package mem_arbiter_pkg.
REQ-029 The winner selection SHALL be a combinational sub-module rr_arb2 (inputs req0, req1, last; outputs winner index and valid).
REQ-030 The implementation SHALL be synthesizable within 120-400 lines of RTL.

Verification
REQ-031 Reset, then req0 write addr=0x0010 data=0xBEEF -> mem_we=1 for one cycle in ACC, done0 pulses 2 cycles after req, then req1 read 0x0010 -> rdata=0xBEEF with done1.
REQ-032 req0 and req1 rise in the same cycle after reset -> gnt0 first and done0, then gnt1 and done1 three cycles later.
REQ-033 Both requests held high for 12 cycles -> exactly 4 completions, alternating 0,1,0,1.
REQ-034 Write at addr=0x7FFF data=0x1234 -> read at 0x7FFF returns 0x1234, and address 0x0000 is not modified.
REQ-035 rst_n driven low mid-ACC of a write -> mem_we=0 in the same cycle, busy=0, no done; next contention is won by requester 0.
REQ-036 req1 read pulsed for one cycle only -> access still completes, done1 pulses once, then the FSM returns to IDLE with busy=0.
